// File: rtl/audio_seq.sv
// audio_seq: codec-init wait, shared sample-strobe divider and per-channel
// ROM address sequencers. Ports: Clk, Reset_n, INIT_FINISH, data_over,
// INIT, tick, trig/stop/loop_en/start_addr/end_addr in, Add/active/done out.
// Optional feature macro: AUDIO_SEQ_AUTOSTART_EN (channel 0 loops whole ROM
// from the first RUN cycle).
module audio_seq #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 17,
  parameter int DEPTH  = 16704,
  parameter int DIV    = 40
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  INIT_FINISH,
  input  logic                  data_over,
  output logic                  INIT,
  output logic                  tick,
  input  logic [NCH-1:0]        trig,
  input  logic [NCH-1:0]        stop,
  input  logic [NCH-1:0]        loop_en,
  input  logic [NCH*ADDR_W-1:0] start_addr,
  input  logic [NCH*ADDR_W-1:0] end_addr,
  output logic [NCH*ADDR_W-1:0] Add,
  output logic [NCH-1:0]        active,
  output logic [NCH-1:0]        done
);

  typedef enum logic {
    WAIT = 1'b0,
    RUN  = 1'b1
  } st_t;

  localparam int CW = $clog2(DIV);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [CW-1:0]     TOP  = CW'(DIV - 1);

`ifdef AUDIO_SEQ_AUTOSTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  st_t           st_q;
  st_t           st_d;
  logic [CW-1:0] cnt_q;
  logic          run;
  logic          enter;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) st_q <= WAIT;
    else          st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      WAIT:    if (INIT_FINISH) st_d = RUN;
      RUN:     st_d = RUN;
      default: st_d = WAIT;
    endcase
  end

  assign run   = (st_q == RUN);
  assign enter = (st_q == WAIT) && INIT_FINISH;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) INIT <= 1'b0;
    else          INIT <= 1'b1;
  end

  // Counter sits at 0 throughout WAIT, so the first RUN cycle is count 0.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)          cnt_q <= '0;
    else if (!run)         cnt_q <= '0;
    else if (cnt_q == TOP) cnt_q <= '0;
    else                   cnt_q <= cnt_q + CW'(1);
  end

  assign tick = run && (cnt_q == TOP);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [ADDR_W-1:0] s_in;
    logic [ADDR_W-1:0] e_in;
    logic [ADDR_W-1:0] e_clp;
    logic [ADDR_W-1:0] add_q;
    logic [ADDR_W-1:0] beg_q;
    logic [ADDR_W-1:0] end_q;
    logic              lp_q;
    logic              act_q;
    logic              done_q;
    logic              ok;
    logic              adv;
    logic              boot;

    assign s_in  = start_addr[i*ADDR_W +: ADDR_W];
    assign e_in  = end_addr[i*ADDR_W +: ADDR_W];
    assign e_clp = (e_in > LAST) ? LAST : e_in;
    // Window check uses the raw end; clamping only trims the latched end.
    assign ok    = (s_in <= e_in) && (s_in <= LAST);
    assign adv   = tick && data_over && act_q;
    assign boot  = AUTO && (i == 0) && enter;

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        add_q  <= '0;
        beg_q  <= '0;
        end_q  <= '0;
        lp_q   <= 1'b0;
        act_q  <= 1'b0;
        done_q <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (boot) begin
          add_q <= '0;
          beg_q <= '0;
          end_q <= LAST;
          lp_q  <= 1'b1;
          act_q <= 1'b1;
        end else if (run) begin
          if (trig[i] && ok) begin
            add_q <= s_in;
            beg_q <= s_in;
            end_q <= e_clp;
            lp_q  <= loop_en[i];
            act_q <= 1'b1;
          end else if (stop[i]) begin
            act_q <= 1'b0;
          end else if (adv) begin
            if (add_q < end_q) begin
              add_q <= add_q + ADDR_W'(1);
            end else begin
              add_q <= beg_q;
              if (!lp_q) begin
                act_q  <= 1'b0;
                done_q <= 1'b1;
              end
            end
          end
        end
      end
    end

    assign Add[i*ADDR_W +: ADDR_W] = add_q;
    assign active[i]               = act_q;
    assign done[i]                 = done_q;
  end

endmodule

// File: tb/tb_audio_seq.sv
// tb_audio_seq: directed self-checking bench for audio_seq.
// Drives on falling edges, samples on falling edges.
module tb_audio_seq;

  localparam int NCH  = 2;
  localparam int AW   = 17;
  localparam int DIVC = 40;

`ifdef AUDIO_SEQ_AUTOSTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              INIT_FINISH = 1'b0;
  logic              data_over = 1'b0;
  logic              INIT;
  logic              tick;
  logic [NCH-1:0]    trig = '0;
  logic [NCH-1:0]    stop = '0;
  logic [NCH-1:0]    loop_en = '0;
  logic [NCH*AW-1:0] start_addr = '0;
  logic [NCH*AW-1:0] end_addr = '0;
  logic [NCH*AW-1:0] Add;
  logic [NCH-1:0]    active;
  logic [NCH-1:0]    done;
  logic [AW-1:0]     a0;
  logic [AW-1:0]     a1;

  int nvec = 0;
  int nerr = 0;

  audio_seq dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .INIT_FINISH(INIT_FINISH),
    .data_over  (data_over),
    .INIT       (INIT),
    .tick       (tick),
    .trig       (trig),
    .stop       (stop),
    .loop_en    (loop_en),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .Add        (Add),
    .active     (active),
    .done       (done)
  );

  always #5 Clk = ~Clk;

  assign a0 = Add[0 +: AW];
  assign a1 = Add[AW +: AW];

  task automatic set_ch(input int ch, input int s, input int e,
                        input bit lp);
    start_addr[ch*AW +: AW] = AW'(s);
    end_addr[ch*AW +: AW]   = AW'(e);
    loop_en[ch]             = lp;
  endtask

  // Returns at the falling edge where tick is high.
  task automatic next_tick();
    bit seen = 1'b0;
    for (int k = 0; k < DIVC + 1; k++) begin
      @(negedge Clk);
      if (tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    nvec++;
    if (!seen) begin
      nerr++;
      $display("FAIL tick_timeout: no tick in %0d cycles, want one",
               DIVC + 1);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    Reset_n   = 1'b0;
    data_over = 1'b1;
    #12;
    nvec++;
    if ({INIT, tick, active, done, Add} !== '0) begin
      nerr++;
      $display("FAIL reset_vals: INIT=%b tick=%b act=%b done=%b Add=%h want 0",
               INIT, tick, active, done, Add);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    set_ch(0, 5, 9, 1'b1);
    set_ch(1, 5, 9, 1'b0);
    trig = 2'b11;
    for (int k = 0; k < 100; k++) begin
      @(negedge Clk);
      if (tick !== 1'b0 || active !== 2'b00) bad++;
      if (k == 5) trig = 2'b00;
    end
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL wait_idle: %0d bad cycles, want 0", bad);
    end
    nvec++;
    if (INIT !== 1'b1 || Add !== '0) begin
      nerr++;
      $display("FAIL wait_init: INIT=%b Add=%h want 1/0", INIT, Add);
    end
  endtask

  task automatic test_first_tick();
    int first = 0;
    int nt = 0;
    INIT_FINISH = 1'b1;
    @(posedge Clk);
    for (int n = 1; n <= 2 * DIVC; n++) begin
      @(negedge Clk);
      if (n == 1) begin
        nvec++;
        if (active[0] !== AUTO || active[1] !== 1'b0) begin
          nerr++;
          $display("FAIL autostart: act=%b want %b0", active, AUTO);
        end
        INIT_FINISH = 1'b0;
      end
      if (tick === 1'b1) begin
        nt++;
        if (first == 0) first = n;
      end
    end
    nvec++;
    if (first != DIVC || nt != 2) begin
      nerr++;
      $display("FAIL first_tick: first=%0d count=%0d want %0d/2",
               first, nt, DIVC);
    end
    nvec++;
    if (a0 !== AW'(AUTO ? 1 : 0) || a1 !== '0) begin
      nerr++;
      $display("FAIL run_add: a0=%0d a1=%0d want %0d/0", a0, a1,
               AUTO ? 1 : 0);
    end
  endtask

  // Trigger lands on a tick edge, so the first tick only loads.
  task automatic test_oneshot();
    int eadd[4] = '{100, 101, 102, 100};
    bit eact[4] = '{1, 1, 1, 0};
    bit edn[4]  = '{0, 0, 0, 1};
    set_ch(1, 100, 102, 1'b0);
    trig = 2'b10;
    @(negedge Clk);
    trig = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        next_tick();
        @(negedge Clk);
      end
      nvec++;
      if (a1 !== AW'(eadd[k]) || active[1] !== eact[k] ||
          done[1] !== edn[k]) begin
        nerr++;
        $display("FAIL oneshot_%0d: Add=%0d act=%b done=%b want %0d/%b/%b",
                 k, a1, active[1], done[1], eadd[k], eact[k], edn[k]);
      end
    end
    @(negedge Clk);
    nvec++;
    if (done[1] !== 1'b0 || active[1] !== 1'b0 || a1 !== AW'(100)) begin
      nerr++;
      $display("FAIL oneshot_after: Add=%0d act=%b done=%b want 100/0/0",
               a1, active[1], done[1]);
    end
  endtask

  task automatic test_dropped();
    int eadd[6] = '{11, 11, 11, 11, 12, 13};
    set_ch(0, 10, 50, 1'b1);
    trig = 2'b01;
    @(negedge Clk);
    trig = 2'b00;
    nvec++;
    if (a0 !== AW'(10) || active[0] !== 1'b1) begin
      nerr++;
      $display("FAIL drop_trig: Add=%0d act=%b want 10/1", a0, active[0]);
    end
    for (int k = 0; k < 6; k++) begin
      next_tick();
      @(negedge Clk);
      nvec++;
      if (a0 !== AW'(eadd[k])) begin
        nerr++;
        $display("FAIL drop_%0d: Add=%0d want %0d", k, a0, eadd[k]);
      end
      if (k == 0) data_over = 1'b0;
      if (k == 3) data_over = 1'b1;
    end
  endtask

  task automatic test_trig_stop();
    next_tick();
    set_ch(0, 500, 520, 1'b1);
    trig = 2'b01;
    stop = 2'b01;
    @(negedge Clk);
    trig = 2'b00;
    stop = 2'b00;
    nvec++;
    if (a0 !== AW'(500) || active[0] !== 1'b1) begin
      nerr++;
      $display("FAIL trig_stop_tick: Add=%0d act=%b want 500/1",
               a0, active[0]);
    end
    next_tick();
    @(negedge Clk);
    nvec++;
    if (a0 !== AW'(501)) begin
      nerr++;
      $display("FAIL trig_adv: Add=%0d want 501", a0);
    end
    set_ch(0, 600, 599, 1'b0);
    trig = 2'b01;
    @(negedge Clk);
    trig = 2'b00;
    nvec++;
    if (a0 !== AW'(501) || active[0] !== 1'b1) begin
      nerr++;
      $display("FAIL bad_window: Add=%0d act=%b want 501/1", a0, active[0]);
    end
    set_ch(0, 17000, 17100, 1'b0);
    trig = 2'b01;
    @(negedge Clk);
    trig = 2'b00;
    nvec++;
    if (a0 !== AW'(501) || active[0] !== 1'b1) begin
      nerr++;
      $display("FAIL bad_start: Add=%0d act=%b want 501/1", a0, active[0]);
    end
    next_tick();
    @(negedge Clk);
    nvec++;
    if (a0 !== AW'(502)) begin
      nerr++;
      $display("FAIL kept_window: Add=%0d want 502", a0);
    end
    stop = 2'b01;
    @(negedge Clk);
    stop = 2'b00;
    nvec++;
    if (a0 !== AW'(502) || active[0] !== 1'b0 || done[0] !== 1'b0) begin
      nerr++;
      $display("FAIL stop: Add=%0d act=%b done=%b want 502/0/0",
               a0, active[0], done[0]);
    end
    next_tick();
    @(negedge Clk);
    nvec++;
    if (a0 !== AW'(502) || active[0] !== 1'b0) begin
      nerr++;
      $display("FAIL idle_hold: Add=%0d act=%b want 502/0", a0, active[0]);
    end
  endtask

  task automatic test_loop_clamp();
    int eadd[5] = '{16700, 16701, 16702, 16703, 16700};
    next_tick();
    set_ch(1, 16700, 20000, 1'b1);
    trig = 2'b10;
    @(negedge Clk);
    trig = 2'b00;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        next_tick();
        @(negedge Clk);
      end
      nvec++;
      if (a1 !== AW'(eadd[k]) || active[1] !== 1'b1 || done[1] !== 1'b0) begin
        nerr++;
        $display("FAIL loop_%0d: Add=%0d act=%b done=%b want %0d/1/0",
                 k, a1, active[1], done[1], eadd[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    set_ch(0, 300, 300, 1'b0);
    set_ch(1, 7, 8, 1'b0);
    trig = 2'b11;
    @(negedge Clk);
    trig = 2'b00;
    nvec++;
    if (a0 !== AW'(300) || a1 !== AW'(7) || active !== 2'b11) begin
      nerr++;
      $display("FAIL retrig: a0=%0d a1=%0d act=%b want 300/7/11",
               a0, a1, active);
    end
    next_tick();
    @(negedge Clk);
    nvec++;
    if (a0 !== AW'(300) || a1 !== AW'(8) || active !== 2'b10 ||
        done !== 2'b01) begin
      nerr++;
      $display("FAIL b2b_t1: a0=%0d a1=%0d act=%b done=%b want 300/8/10/01",
               a0, a1, active, done);
    end
    next_tick();
    @(negedge Clk);
    nvec++;
    if (a0 !== AW'(300) || a1 !== AW'(7) || active !== 2'b00 ||
        done !== 2'b10) begin
      nerr++;
      $display("FAIL b2b_t2: a0=%0d a1=%0d act=%b done=%b want 300/7/00/10",
               a0, a1, active, done);
    end
  endtask

  task automatic test_async_reset();
    set_ch(1, 1000, 2000, 1'b1);
    trig = 2'b10;
    @(negedge Clk);
    trig = 2'b00;
    next_tick();
    @(negedge Clk);
    nvec++;
    if (a1 !== AW'(1001) || active[1] !== 1'b1) begin
      nerr++;
      $display("FAIL pre_reset: Add=%0d act=%b want 1001/1", a1, active[1]);
    end
    #2;
    Reset_n = 1'b0;
    #1;
    nvec++;
    if ({INIT, tick, active, done, Add} !== '0) begin
      nerr++;
      $display("FAIL async_reset: INIT=%b act=%b Add=%h want 0",
               INIT, active, Add);
    end
    @(negedge Clk);
    nvec++;
    if ({INIT, tick, active, Add} !== '0) begin
      nerr++;
      $display("FAIL reset_hold: INIT=%b act=%b Add=%h want 0",
               INIT, active, Add);
    end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_oneshot();
    test_dropped();
    test_trig_stop();
    test_loop_clamp();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
